// File: rtl/l1_refill_ctrl.sv
// l1_refill_ctrl
//   Fetches one cache line from the next memory level after a lookup miss and
//   writes the returned beats into the L1 data memory, in order from the line base.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   miss_req/addr     miss strobe and word address; accepted only when idle
//   busy              refill in progress; miss_req is ignored while high
//   mem_req_val/addr  line read request, held until mem_req_ack
//   mem_req_ack       next level takes the request
//   mem_rsp_val/data  refill beats; gaps of any length allowed
//   wen/waddr/wdata   data memory write port; zero when no write is made
//   refill_done       one-cycle pulse after the last beat is written
module l1_refill_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter int BEATS = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int BW   = $clog2(BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miss_req,
  input  logic [AW-1:0]    miss_addr,
  output logic             busy,
  output logic             mem_req_val,
  output logic [AW-1:0]    mem_req_addr,
  input  logic             mem_req_ack,
  input  logic             mem_rsp_val,
  input  logic [WIDTH-1:0] mem_rsp_data,
  output logic             wen,
  output logic [AW-1:0]    waddr,
  output logic [WIDTH-1:0] wdata,
  output logic             refill_done
);

  typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [BW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode the registered state only, so mem_req_val never has a
  // combinational path from miss_req or mem_req_ack. The write port is the one
  // intentional input-to-output path: beats are written in the cycle they arrive.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    cnt_d        = cnt_q;
    busy         = 1'b1;
    mem_req_val  = 1'b0;
    mem_req_addr = '0;
    wen          = 1'b0;
    waddr        = '0;
    wdata        = '0;
    refill_done  = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (miss_req) begin
          // Masking (rather than slicing) keeps this legal when BEATS == DEPTH.
          base_d  = miss_addr & ~AW'(BEATS - 1);
          cnt_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        mem_req_val  = 1'b1;
        mem_req_addr = base_q;
        if (mem_req_ack) state_d = FILL;
      end
      FILL: begin
        if (mem_rsp_val) begin
          wen   = 1'b1;
          waddr = base_q + AW'(cnt_q);
          wdata = mem_rsp_data;
          // Counter is exactly BW bits, so the last beat wraps it back to 0.
          cnt_d = cnt_q + BW'(1);
          if (cnt_q == BW'(BEATS - 1)) state_d = DONE;
        end
      end
      DONE: begin
        refill_done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l1_refill_ctrl.sv
module tb_l1_refill_ctrl;
  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
  localparam int BEATS = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             miss_req;
  logic [AW-1:0]    miss_addr;
  logic             busy;
  logic             mem_req_val;
  logic [AW-1:0]    mem_req_addr;
  logic             mem_req_ack;
  logic             mem_rsp_val;
  logic [WIDTH-1:0] mem_rsp_data;
  logic             wen;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic             refill_done;

  l1_refill_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BEATS(BEATS)) dut (
    .clk(clk), .rst_n(rst_n),
    .miss_req(miss_req), .miss_addr(miss_addr), .busy(busy),
    .mem_req_val(mem_req_val), .mem_req_addr(mem_req_addr), .mem_req_ack(mem_req_ack),
    .mem_rsp_val(mem_rsp_val), .mem_rsp_data(mem_rsp_data),
    .wen(wen), .waddr(waddr), .wdata(wdata), .refill_done(refill_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
  } wr_t;

  // Scoreboard queues, filled by the stimulus side and drained by the monitor.
  logic [AW-1:0] req_q[$];
  wr_t           wr_q[$];
  int            done_q[$];

  // Cycle-level protocol expectations set by the stimulus side.
  logic exp_busy = 1'b0, exp_req = 1'b0, exp_wen = 1'b0;
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic fail_empty(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=unexpected-output want=nothing-pending cycle=%0d", name, cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("mem_req_val", 64'(mem_req_val), 64'(exp_req));
      if (mem_req_val) begin
        if (req_q.size() == 0) fail_empty("mem_req_val");
        else begin
          chk("mem_req_addr", 64'(mem_req_addr), 64'(req_q[0]));
          if (mem_req_ack) void'(req_q.pop_front());
        end
      end else chk("mem_req_addr_zero", 64'(mem_req_addr), 64'd0);
      chk("wen", 64'(wen), 64'(exp_wen));
      if (wen) begin
        if (wr_q.size() == 0) fail_empty("wen");
        else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("waddr", 64'(waddr), 64'(e.a));
          chk("wdata", 64'(wdata), 64'(e.d));
        end
      end else begin
        chk("waddr_zero", 64'(waddr), 64'd0);
        chk("wdata_zero", 64'(wdata), 64'd0);
      end
      if (refill_done) begin
        if (done_q.size() == 0) fail_empty("refill_done");
        else chk("refill_done_cycle", 64'(cyc), 64'(done_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 64'({busy, mem_req_val, mem_req_addr, wen, waddr, wdata, refill_done}), 64'd0);
  endtask

  // One complete refill of the line holding addr. ack_dly idle REQ cycles before
  // the ack; gmin..gmax empty cycles before each beat; noise pulses miss_req and
  // mem_rsp_val where they must be ignored; abort_after > 0 resets after that many beats.
  task automatic run_line(input logic [AW-1:0] addr, input int ack_dly, input int gmin,
                          input int gmax, input bit noise, input bit directed,
                          input int abort_after);
    logic [AW-1:0]    base;
    logic [WIDTH-1:0] d;
    wr_t              e;
    int               gaps;
    base = AW'((int'(addr) / BEATS) * BEATS);
    // Acceptance cycle: no request visible yet.
    miss_req = 1'b1; miss_addr = addr; mem_rsp_val = 1'b0; mem_req_ack = 1'b0;
    req_q.push_back(base);
    tick();
    miss_req = 1'b0; exp_req = 1'b1; exp_busy = 1'b1;
    for (int i = 0; i <= ack_dly; i++) begin
      if (i > 0) tick();
      mem_req_ack = (i == ack_dly);
      if (noise) begin
        miss_req     = 1'($urandom_range(0, 1));
        miss_addr    = AW'($urandom);
        mem_rsp_val  = 1'($urandom_range(0, 1));
        mem_rsp_data = $urandom;
      end
    end
    tick();
    exp_req = 1'b0; mem_req_ack = 1'b0; miss_req = 1'b0; mem_rsp_val = 1'b0;
    for (int k = 0; k < BEATS; k++) begin
      if (abort_after > 0 && k == abort_after) begin
        exp_wen = 1'b0; mem_rsp_val = 1'b1; mem_rsp_data = $urandom;
        #2 rst_n = 1'b0;
        #1 chk_all_zero("reset_mid_refill");
        req_q.delete(); wr_q.delete(); done_q.delete();
        exp_busy = 1'b0;
        tick();
        chk_all_zero("reset_held");
        mem_rsp_val = 1'b0;
        tick();
        rst_n = 1'b1;
        return;
      end
      gaps = $urandom_range(gmin, gmax);
      for (int g = 0; g < gaps; g++) begin
        exp_wen = 1'b0; mem_rsp_val = 1'b0; mem_rsp_data = $urandom;
        miss_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        miss_addr = AW'($urandom);
        tick();
      end
      d = directed ? WIDTH'(32'hA0 + k) : WIDTH'($urandom);
      e.a = base + AW'(k);
      e.d = d;
      wr_q.push_back(e);
      exp_wen = 1'b1; mem_rsp_val = 1'b1; mem_rsp_data = d;
      miss_req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
    end
    // Done cycle, one after the last beat.
    exp_wen = 1'b0; mem_rsp_val = 1'b0; miss_req = 1'b0;
    done_q.push_back(cyc);
    tick();
    exp_busy = 1'b0;
    if (noise) begin
      // Idle cycle: stray beat and ack must have no effect.
      mem_rsp_val = 1'b1; mem_rsp_data = $urandom; mem_req_ack = 1'b1;
      tick();
      mem_rsp_val = 1'b0; mem_req_ack = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; miss_req = 1'b0; miss_addr = '0; mem_req_ack = 1'b0;
    mem_rsp_val = 1'b0; mem_rsp_data = '0;
    tick();
    mem_rsp_val = 1'b1; miss_req = 1'b1;
    #1 chk_all_zero("reset_state");
    tick();
    mem_rsp_val = 1'b0; miss_req = 1'b0;
    rst_n = 1'b1;
    tick();

    run_line(AW'(10'h00D), 0, 0, 0, 1'b0, 1'b1, 0);   // basic line, back-to-back beats
    run_line(AW'($urandom), 5, 0, 0, 1'b0, 1'b0, 0);  // delayed ack
    run_line(AW'($urandom), 1, 2, 2, 1'b0, 1'b0, 0);  // 2-cycle gaps
    run_line(AW'($urandom), 2, 0, 2, 1'b1, 1'b0, 0);  // ignored miss/rsp/ack noise
    run_line(AW'(10'h3FF), 0, 0, 1, 1'b0, 1'b0, 0);   // top line
    run_line(AW'($urandom), 1, 0, 0, 1'b0, 1'b0, 2);  // reset after 2 beats
    run_line(AW'(10'h105), 0, 0, 0, 1'b0, 1'b1, 0);   // fresh refill from beat 0
    for (int n = 0; n < 25; n++)
      run_line(AW'($urandom), $urandom_range(0, 4), 0, $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'b0, 0);

    tick();
    tick();
    chk("req_q_drained", 64'(req_q.size()), 64'd0);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
    chk("done_q_drained", 64'(done_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1);
  end

endmodule
